// File: rtl/fixed_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-point multiplier among NREQ requesters.
// A single result register holds the product and the owning requester's index.

module fixed_mul #(
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = W / 2
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] prod_c_o
);

  logic signed [2*W-1:0] full_c;

  // Full-precision product realigned to the operand format, upper bits dropped
  always_comb begin
    full_c   = a_i * b_i;
    prod_c_o = W'(full_c >>> FRAC);
  end

endmodule

module fixed_mul_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NREQ-1:0]                       req_valid,
  output logic [NREQ-1:0]                       req_ready,
  input  logic [NREQ*W-1:0]                     req_a,
  input  logic [NREQ*W-1:0]                     req_b,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [W-1:0]                          rsp_result,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           can_accept;
  logic           gnt_vld;
  logic [IDW-1:0] gnt;
  logic           xfer;
  logic [W-1:0]   op_a, op_b;
  logic [W-1:0]   prod;

  // Round-robin search starting at ptr_q
  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && req_valid[IDW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt     = IDW'(idx);
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        op_a = req_a[i*W +: W];
        op_b = req_b[i*W +: W];
      end
    end
  end

  fixed_mul #(.W(W)) u_mul (
    .a_i      (op_a),
    .b_i      (op_b),
    .prod_c_o (prod)
  );

  // Handshake and next-state for the result register and pointer
  always_comb begin
    can_accept   = !rsp_valid_q || rsp_ready;
    req_ready    = '0;
    xfer         = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    ptr_d        = ptr_q;

    if (rst_n && can_accept && gnt_vld) begin
      req_ready[gnt] = 1'b1;
      xfer           = 1'b1;
    end

    if (xfer) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = prod;
      rsp_id_d     = gnt;
      ptr_d        = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
      ptr_q        <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      ptr_q        <= ptr_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
// Bench for fixed_mul_arbiter: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the arbiter.

module tb_fixed_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_result;
  logic [1:0]      rsp_id;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state
  bit          m_valid  = 1'b0;
  logic [15:0] m_result = '0;
  int          m_id     = 0;
  int          m_ptr    = 0;

  fixed_mul_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_mul(logic [15:0] a, logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 8;
    return p[15:0];
  endfunction

  function automatic int m_grant(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    int g;
    logic [NREQ-1:0] r;
    r = '0;
    g = m_grant(req_valid, m_ptr);
    if (rst_n && (!m_valid || rsp_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(int i, logic [15:0] a, logic [15:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Model advance at each rising edge
  always @(posedge clk) begin
    int g;
    if (!rst_n) begin
      m_valid = 1'b0; m_result = '0; m_id = 0; m_ptr = 0;
    end else begin
      g = m_grant(req_valid, m_ptr);
      if ((!m_valid || rsp_ready) && g >= 0) begin
        m_result = m_mul(req_a[g*W +: W], req_b[g*W +: W]);
        m_id     = g;
        m_valid  = 1'b1;
        m_ptr    = (g + 1) % NREQ;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(m_ready()));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rsp_result", 32'(rsp_result), 32'(m_result));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
    end
  end

  int seq_fair[6] = '{0, 1, 2, 3, 0, 1};
  int seq_sparse[4] = '{1, 3, 1, 3};

  initial begin
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b0;
    req_a = '0; req_b = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_result", 32'(rsp_result), 0);
    chk("rst_ready", 32'(req_ready), 0);
    @(posedge clk); #1;

    // Single op from requester 0
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'b0001;
    set_op(0, 16'h0200, 16'h0300);
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_result", 32'(rsp_result), 32'h0600);
    chk("single_id", 32'(rsp_id), 0);

    // Signed product from requester 2
    @(posedge clk); #1;
    req_valid = 4'b0100; set_op(2, 16'hFF00, 16'h0200);
    @(negedge clk);
    chk("signed_ready", 32'(req_ready), 32'h4);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    chk("signed_result", 32'(rsp_result), 32'hFE00);
    chk("signed_id", 32'(rsp_id), 2);

    // Fairness with all requesters active
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("fair_id", 32'(rsp_id), 32'(seq_fair[i]));
      chk("fair_valid", 32'(rsp_valid), 1);
    end

    // Reset in the middle of the stream
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(rsp_valid), 0);
    chk("midrst_result", 32'(rsp_result), 0);
    chk("midrst_id", 32'(rsp_id), 0);
    chk("midrst_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_first", 32'(rsp_id), 0);

    // Sparse requesters with idle gaps
    @(posedge clk); #1; rst_n = 1'b0; req_valid = '0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      req_valid = 4'b1010;
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk);
      chk("sparse_id", 32'(rsp_id), 32'(seq_sparse[j]));
      repeat (3) @(posedge clk);
      #1;
    end

    // Backpressure: consumer stalls for 5 cycles
    req_valid = 4'b1111; rsp_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    chk("bp_release_id", 32'(rsp_id), 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 99) != 0);
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
